// File: rtl/demux_1xn_reg.sv
// Registered 1-to-N demultiplexer with a per-channel valid/ready output slot.
// The word is steered either by Sel (direct) or by an internal round-robin
// pointer that advances once per accepted word.

// One output slot: holds a word until its consumer takes it.
module demux_1xn_lane #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             acc_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] out_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] out_q, out_d;

  // Load wins over drain so a simultaneous replace leaves no bubble.
  always_comb begin
    valid_d = valid_q;
    out_d   = out_q;
    if (acc_i) begin
      valid_d = 1'b1;
      out_d   = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Slot registers; the word is held after draining, cleared only by reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

  assign valid_o = valid_q;
  assign out_o   = out_q;

endmodule

module demux_1xn_reg #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 4,
  parameter int SEL_W = 2
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Mode,
  input  logic [SEL_W-1:0]       Sel,
  input  logic                   E,
  input  logic [WIDTH-1:0]       Data,
  output logic                   In_Ready,
  input  logic [N_OUT-1:0]       Ready,
  output logic [N_OUT-1:0]       Valid,
  output logic [N_OUT*WIDTH-1:0] Out,
  output logic [SEL_W-1:0]       Ptr
);

  logic [SEL_W-1:0]            ptr_q, ptr_d;
  logic [SEL_W-1:0]            tgt;
  logic                        accept;
  logic [N_OUT-1:0]            acc_vec;
  logic [N_OUT-1:0][WIDTH-1:0] out_w;

  // Target channel, input readiness and per-lane accept strobe.
  always_comb begin
    tgt      = Mode ? ptr_q : Sel;
    In_Ready = !Valid[tgt] || Ready[tgt];
    accept   = E && In_Ready;
    acc_vec  = '0;
    acc_vec[tgt] = accept;
    // Power-of-two N_OUT makes the natural SEL_W overflow the wrap.
    ptr_d    = (accept && Mode) ? ptr_q + 1'b1 : ptr_q;
  end

  // Round-robin pointer; held in direct mode and across mode switches.
  always_ff @(posedge Clk) begin
    if (Reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign Ptr = ptr_q;

  for (genvar k = 0; k < N_OUT; k++) begin : g_lane
    demux_1xn_lane #(.WIDTH(WIDTH)) u_lane (
      .Clk     (Clk),
      .Reset   (Reset),
      .acc_i   (acc_vec[k]),
      .data_i  (Data),
      .ready_i (Ready[k]),
      .valid_o (Valid[k]),
      .out_o   (out_w[k])
    );
    assign Out[k*WIDTH +: WIDTH] = out_w[k];
  end

endmodule

// File: tb/tb_demux_1xn_reg.sv
// Bench for demux_1xn_reg: a directed vector table covering reset, direct,
// back-pressure, round-robin wrap/stall and mid-run reset, followed by
// random traffic compared against a channel-slot reference model.
module tb_demux_1xn_reg;

  localparam int W = 8;
  localparam int N = 4;
  localparam int S = 2;

  logic           Clk = 1'b0;
  logic           Reset, Mode, E, In_Ready;
  logic [S-1:0]   Sel, Ptr;
  logic [W-1:0]   Data;
  logic [N-1:0]   Ready, Valid;
  logic [N*W-1:0] Out;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [W-1:0] m_o [N];
  logic         m_v [N];
  int           m_ptr;
  bit           m_known = 0;

  always #5 Clk = ~Clk;

  demux_1xn_reg #(.WIDTH(W), .N_OUT(N), .SEL_W(S)) dut (
    .Clk(Clk), .Reset(Reset), .Mode(Mode), .Sel(Sel), .E(E), .Data(Data),
    .In_Ready(In_Ready), .Ready(Ready), .Valid(Valid), .Out(Out), .Ptr(Ptr)
  );

  typedef struct {
    logic       rst;
    logic       mode;
    logic [1:0] sel;
    logic       e;
    logic [7:0] data;
    logic [3:0] rdy;
    logic       chk_ir;
    logic       ir;
    logic [3:0] v;
    logic [1:0] p;
  } vec_t;

  vec_t tbl[34];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic model_ir(input logic mode, input logic [1:0] sel, input logic [3:0] rdy);
    int t;
    t = mode ? m_ptr : int'(sel);
    return !m_v[t] || rdy[t];
  endfunction

  // Slot semantics: every full+ready slot empties, then the target slot
  // (if it had room) takes the word, which also covers replace-on-drain.
  task automatic model_step(input logic rst, input logic mode, input logic [1:0] sel,
                            input logic e, input logic [7:0] data, input logic [3:0] rdy);
    int  t;
    bit  room;
    if (rst) begin
      for (int k = 0; k < N; k++) begin m_v[k] = 0; m_o[k] = '0; end
      m_ptr   = 0;
      m_known = 1;
      return;
    end
    t    = mode ? m_ptr : int'(sel);
    room = !m_v[t] || rdy[t];
    for (int k = 0; k < N; k++) if (m_v[k] && rdy[k]) m_v[k] = 0;
    if (e && room) begin
      m_v[t] = 1;
      m_o[t] = data;
      if (mode) m_ptr = (m_ptr + 1) % N;
    end
  endtask

  function automatic logic [N*W-1:0] model_out();
    logic [N*W-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = m_o[k];
    return r;
  endfunction

  function automatic logic [N-1:0] model_valid();
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = m_v[k];
    return r;
  endfunction

  // Drive at negedge, check In_Ready before the edge, check state after it.
  task automatic apply(input logic rst, input logic mode, input logic [1:0] sel,
                       input logic e, input logic [7:0] data, input logic [3:0] rdy);
    Reset = rst; Mode = mode; Sel = sel; E = e; Data = data; Ready = rdy;
    #1;
    if (m_known && !rst) chk("in_ready_model", 64'(In_Ready), 64'(model_ir(mode, sel, rdy)));
    @(posedge Clk);
    model_step(rst, mode, sel, e, data, rdy);
    @(negedge Clk);
    chk("valid_model", 64'(Valid), 64'(model_valid()));
    chk("out_model",   64'(Out),   64'(model_out()));
    chk("ptr_model",   64'(Ptr),   64'(m_ptr));
  endtask

  function automatic vec_t mk(input logic rst, input logic mode, input logic [1:0] sel,
                              input logic e, input logic [7:0] d, input logic [3:0] rdy,
                              input logic chk_ir, input logic ir, input logic [3:0] v,
                              input logic [1:0] p);
    vec_t x;
    x.rst = rst; x.mode = mode; x.sel = sel; x.e = e; x.data = d; x.rdy = rdy;
    x.chk_ir = chk_ir; x.ir = ir; x.v = v; x.p = p;
    return x;
  endfunction

  initial begin
    //           rst mode sel e  data   rdy     cir ir  valid    ptr
    // reset held two cycles with a pending word
    tbl[0]  = mk(1, 0, 0, 1, 8'hAA, 4'b1111, 0, 0, 4'b0000, 0);
    tbl[1]  = mk(1, 0, 0, 1, 8'hAA, 4'b1111, 1, 1, 4'b0000, 0);
    // direct mode, one word per channel, consumers always ready
    tbl[2]  = mk(0, 0, 0, 1, 8'h10, 4'b1111, 1, 1, 4'b0001, 0);
    tbl[3]  = mk(0, 0, 1, 1, 8'h11, 4'b1111, 1, 1, 4'b0010, 0);
    tbl[4]  = mk(0, 0, 2, 1, 8'h12, 4'b1111, 1, 1, 4'b0100, 0);
    tbl[5]  = mk(0, 0, 3, 1, 8'h13, 4'b1111, 1, 1, 4'b1000, 0);
    tbl[6]  = mk(0, 0, 3, 0, 8'h00, 4'b1111, 1, 1, 4'b0000, 0);
    // back-pressure on channel 2
    tbl[7]  = mk(0, 0, 2, 1, 8'h55, 4'b1011, 1, 1, 4'b0100, 0);
    tbl[8]  = mk(0, 0, 2, 1, 8'h66, 4'b1011, 1, 0, 4'b0100, 0);
    tbl[9]  = mk(0, 0, 2, 1, 8'h66, 4'b1011, 1, 0, 4'b0100, 0);
    tbl[10] = mk(0, 0, 2, 1, 8'h66, 4'b1111, 1, 1, 4'b0100, 0);
    tbl[11] = mk(0, 0, 2, 0, 8'h00, 4'b1111, 1, 1, 4'b0000, 0);
    // round-robin wrap, Data 1..6
    tbl[12] = mk(0, 1, 0, 1, 8'd1,  4'b1111, 1, 1, 4'b0001, 1);
    tbl[13] = mk(0, 1, 0, 1, 8'd2,  4'b1111, 1, 1, 4'b0010, 2);
    tbl[14] = mk(0, 1, 0, 1, 8'd3,  4'b1111, 1, 1, 4'b0100, 3);
    tbl[15] = mk(0, 1, 0, 1, 8'd4,  4'b1111, 1, 1, 4'b1000, 0);
    tbl[16] = mk(0, 1, 0, 1, 8'd5,  4'b1111, 1, 1, 4'b0001, 1);
    tbl[17] = mk(0, 1, 0, 1, 8'd6,  4'b1111, 1, 1, 4'b0010, 2);
    tbl[18] = mk(0, 1, 0, 0, 8'd0,  4'b1111, 1, 1, 4'b0000, 2);
    // build up Ptr=1 with channel 1 full and stalled
    tbl[19] = mk(0, 1, 0, 1, 8'h20, 4'b1111, 1, 1, 4'b0100, 3);
    tbl[20] = mk(0, 1, 0, 1, 8'h21, 4'b1101, 1, 1, 4'b1000, 0);
    tbl[21] = mk(0, 1, 0, 1, 8'h22, 4'b1101, 1, 1, 4'b0001, 1);
    tbl[22] = mk(0, 1, 0, 1, 8'h23, 4'b1101, 1, 1, 4'b0010, 2);
    tbl[23] = mk(0, 1, 0, 1, 8'h24, 4'b1101, 1, 1, 4'b0110, 3);
    tbl[24] = mk(0, 1, 0, 1, 8'h25, 4'b1101, 1, 1, 4'b1010, 0);
    tbl[25] = mk(0, 1, 0, 1, 8'h26, 4'b1101, 1, 1, 4'b0011, 1);
    tbl[26] = mk(0, 1, 0, 1, 8'h27, 4'b1101, 1, 0, 4'b0010, 1);
    tbl[27] = mk(0, 1, 0, 1, 8'h27, 4'b1101, 1, 0, 4'b0010, 1);
    // replace-on-drain at channel 1, then build Valid=1011 with Ptr=3
    tbl[28] = mk(0, 1, 0, 1, 8'h30, 4'b0010, 1, 1, 4'b0010, 2);
    tbl[29] = mk(0, 1, 0, 1, 8'h31, 4'b0000, 1, 1, 4'b0110, 3);
    tbl[30] = mk(0, 0, 0, 1, 8'h32, 4'b0100, 1, 1, 4'b0011, 3);
    tbl[31] = mk(0, 0, 3, 1, 8'h33, 4'b0000, 1, 1, 4'b1011, 3);
    // reset with an acceptable word present
    tbl[32] = mk(1, 1, 0, 1, 8'h34, 4'b1000, 1, 1, 4'b0000, 0);
    tbl[33] = mk(0, 1, 0, 0, 8'h00, 4'b0000, 1, 1, 4'b0000, 0);

    Reset = 1; Mode = 0; Sel = 0; E = 0; Data = 0; Ready = 0;
    for (int k = 0; k < N; k++) begin m_v[k] = 0; m_o[k] = '0; end
    m_ptr = 0;
    @(negedge Clk);

    for (int i = 0; i < 34; i++) begin
      Reset = tbl[i].rst; Mode = tbl[i].mode; Sel = tbl[i].sel; E = tbl[i].e;
      Data = tbl[i].data; Ready = tbl[i].rdy;
      #1;
      if (tbl[i].chk_ir) chk($sformatf("vec%0d_in_ready", i), 64'(In_Ready), 64'(tbl[i].ir));
      @(negedge Clk);
      chk($sformatf("vec%0d_valid", i), 64'(Valid), 64'(tbl[i].v));
      chk($sformatf("vec%0d_ptr", i),   64'(Ptr),   64'(tbl[i].p));
      // keep the reference model in lockstep for the random phase
      model_step(tbl[i].rst, tbl[i].mode, tbl[i].sel, tbl[i].e, tbl[i].data, tbl[i].rdy);
      if (i == 8 || i == 9) chk($sformatf("vec%0d_out2_held", i), 64'(Out[2*W +: W]), 64'(8'h55));
      if (i == 10) chk("bp_out2_new", 64'(Out[2*W +: W]), 64'(8'h66));
      if (i == 17) chk("rr_out_order", 64'(Out), 64'({8'd4, 8'd3, 8'd6, 8'd5}));
      if (i == 27) chk("rr_stall_out", 64'(Out[1*W +: W]), 64'(8'h23));
      if (i == 32) chk("rst_out_clear", 64'(Out), 64'(0));
    end

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 39) == 0), 1'($urandom), 2'($urandom), 1'($urandom),
            8'($urandom), 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
